// File: rtl/instr_loader.sv
// Byte-stream program loader: unpacks {HI,LO} pairs into 10-bit words for imem.
// Optional trailing XOR checksum when INSTR_LOADER_CHECKSUM_EN is defined.
module instr_loader #(
    parameter logic [9:0] BASE_ADDR = 10'h000,
    parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       mem_we,
    output logic [9:0] mem_addr,
    output logic [9:0] mem_wdata,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_CHK,
        S_DONE
    } state_t;

    state_t     state_q;
    logic [7:0] idx_q;
    logic [7:0] last_q;
    logic [1:0] hi_q;
    logic       mem_we_q;
    logic [9:0] mem_addr_q;
    logic [9:0] mem_wdata_q;
    logic       done_q;
    logic [9:0] addr_d;
    logic       accept;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] chk_q;
    logic       err_q;
`endif

    assign accept = rx_valid && rx_ready;
    // 10-bit add wraps 0x3FF -> 0x000 by construction
    assign addr_d = BASE_ADDR + {2'b00, idx_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            last_q      <= '0;
            hi_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            chk_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            err_q    <= 1'b0;
`endif
            if (state_q == S_DONE) begin
                state_q <= S_IDLE;
            end else if (accept) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (rx_data == HDR_BYTE)
                            state_q <= S_LEN;
                    end
                    S_LEN: begin
                        // LEN=0 wraps to last index 255, i.e. 256 words
                        last_q  <= rx_data - 8'd1;
                        idx_q   <= '0;
                        state_q <= S_HI;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        chk_q   <= rx_data;
`endif
                    end
                    S_HI: begin
                        hi_q    <= rx_data[1:0];
                        state_q <= S_LO;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        chk_q   <= chk_q ^ rx_data;
`endif
                    end
                    S_LO: begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= {hi_q, rx_data};
`ifdef INSTR_LOADER_CHECKSUM_EN
                        chk_q       <= chk_q ^ rx_data;
`endif
                        if (idx_q == last_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                            state_q <= S_CHK;
`else
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            idx_q   <= idx_q + 8'd1;
                            state_q <= S_HI;
                        end
                    end
`ifdef INSTR_LOADER_CHECKSUM_EN
                    S_CHK: begin
                        if (rx_data == chk_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                        end
                    end
`endif
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_ready  = (state_q != S_DONE);
    assign cpu_hold  = (state_q != S_IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign load_done = done_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    assign load_err  = err_q;
`else
    assign load_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes queued at stimulus time,
// popped by per-instance monitors whenever mem_we is seen.
module tb_instr_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       vld0, vld1;
    logic       rdy0, rdy1;
    logic       we0, we1;
    logic [9:0] addr0, addr1, wd0, wd1;
    logic       hold0, hold1, done0, done1, err0, err1;

    int errors = 0;
    int checks = 0;
    int sel = 0;

    logic [19:0] q0[$];
    logic [19:0] q1[$];
    logic [9:0]  words[256];

    always #5 clk = ~clk;

    instr_loader #(.BASE_ADDR(10'h000), .HDR_BYTE(8'hA5)) u_dut0 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(vld0),
        .rx_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
        .cpu_hold(hold0), .load_done(done0), .load_err(err0)
    );

    instr_loader #(.BASE_ADDR(10'h3F0), .HDR_BYTE(8'hA5)) u_dut1 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(vld1),
        .rx_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
        .cpu_hold(hold1), .load_done(done1), .load_err(err1)
    );

    wire c_rdy  = sel ? rdy1  : rdy0;
    wire c_hold = sel ? hold1 : hold0;
    wire c_done = sel ? done1 : done0;
    wire c_err  = sel ? err1  : err0;
    wire c_we   = sel ? we1   : we0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitors: every observed write must match the oldest expected one
    always @(negedge clk) begin
        if (we0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL wr0_spurious: got %0h@%0h, expected none", wd0, addr0);
            end else begin
                logic [19:0] e;
                e = q0.pop_front();
                if ({addr0, wd0} !== e) begin
                    errors++;
                    $display("FAIL wr0: got %0h@%0h, expected %0h@%0h",
                             wd0, addr0, e[9:0], e[19:10]);
                end
            end
        end
        if (we1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL wr1_spurious: got %0h@%0h, expected none", wd1, addr1);
            end else begin
                logic [19:0] e;
                e = q1.pop_front();
                if ({addr1, wd1} !== e) begin
                    errors++;
                    $display("FAIL wr1: got %0h@%0h, expected %0h@%0h",
                             wd1, addr1, e[9:0], e[19:10]);
                end
            end
        end
    end

    // Called and returning at a negedge; byte is accepted on the posedge in between
    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_data = b;
        if (sel == 0) vld0 = 1'b1; else vld1 = 1'b1;
        while (!c_rdy && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!c_rdy) begin
            errors++;
            $display("FAIL rdy_timeout: got 0, expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        vld0 = 1'b0;
        vld1 = 1'b0;
    endtask

    task automatic frame(input int n, input logic [7:0] len,
                         input logic [7:0] ck, input bit good);
        logic [9:0] base;
        base = sel ? 10'h3F0 : 10'h000;
        for (int i = 0; i < n; i++) begin
            logic [9:0] a;
            a = base + 10'(i);
            if (sel == 0) q0.push_back({a, words[i]});
            else          q1.push_back({a, words[i]});
        end
        send(8'hA5);
        chk("hold_rise", c_hold, 1);
        send(len);
        for (int i = 0; i < n; i++) begin
            send({6'b0, words[i][9:8]});
            send(words[i][7:0]);
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        send(ck);
`endif
        if (good) begin
            chk("done_pulse", c_done, 1);
            chk("err_quiet", c_err, 0);
            chk("hold_in_done", c_hold, 1);
            chk("rdy_in_done", c_rdy, 0);
            @(negedge clk);
            chk("done_once", c_done, 0);
            chk("hold_fall", c_hold, 0);
        end else begin
            chk("err_pulse", c_err, 1);
            chk("no_done", c_done, 0);
            chk("hold_drop", c_hold, 0);
            @(negedge clk);
            chk("err_once", c_err, 0);
            chk("no_done_late", c_done, 0);
        end
    endtask

    initial begin
        reset = 1'b1;
        rx_data = '0;
        vld0 = 1'b0;
        vld1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_we", we0, 0);
        chk("rst_addr", addr0, 0);
        chk("rst_wdata", wd0, 0);
        chk("rst_hold", hold0, 0);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);
        chk("rst_rdy", rdy0, 1);
        repeat (3) @(negedge clk);

        // Basic two-word load
        words[0] = 10'h123;
        words[1] = 10'h2FF;
        frame(2, 8'h02, 8'hDD, 1'b1);
        repeat (2) @(negedge clk);

        // Junk before header is dropped
        send(8'h00);
        chk("junk0_hold", c_hold, 0);
        send(8'h5A);
        chk("junk1_hold", c_hold, 0);
        words[0] = 10'h3FF;
        frame(1, 8'h01, 8'hFD, 1'b1);
        repeat (2) @(negedge clk);

        // Bad checksum (or plain load when checksum is compiled out)
        words[0] = 10'h123;
        words[1] = 10'h2FF;
`ifdef INSTR_LOADER_CHECKSUM_EN
        frame(2, 8'h02, 8'hDC, 1'b0);
`else
        frame(2, 8'h02, 8'hDC, 1'b1);
`endif
        repeat (2) @(negedge clk);

        // Reset mid-frame after one word
        q0.push_back({10'h000, 10'h123});
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        send(8'h23);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_hold", hold0, 0);
        chk("midrst_rdy", rdy0, 1);
        chk("midrst_we", we0, 0);
        repeat (4) @(negedge clk);
        chk("midrst_pending", q0.size(), 0);
        words[0] = 10'h0AB;
        words[1] = 10'h301;
        frame(2, 8'h02, 8'h02 ^ 8'h00 ^ 8'hAB ^ 8'h03 ^ 8'h01, 1'b1);
        repeat (2) @(negedge clk);

        // 256-word load on the wrapping instance; XOR of all bytes is 0
        sel = 1;
        for (int i = 0; i < 256; i++) words[i] = 10'(i);
        frame(256, 8'h00, 8'h00, 1'b1);
        repeat (4) @(negedge clk);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

endmodule
